// File: rtl/anim_step_ctrl.sv
// Animation sequencer: emits a one-cycle step strobe every tm_value clocks and
// walks the frame index in wrap or ping-pong order, with run/pause/single-step.
module anim_step_ctrl #(
    parameter int unsigned TM_WIDTH  = 27,
    parameter int unsigned FRAMES    = 8,
    parameter int unsigned IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TM_WIDTH-1:0]  tm_value,
    input  logic                 count_en,
    input  logic                 btn_pause,
    input  logic                 btn_step,
    input  logic                 pingpong,
    output logic                 step,
    output logic [IDX_WIDTH-1:0] frame_idx,
    output logic                 dir,
    output logic                 running
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(FRAMES - 1);

    state_t               state, state_nx;
    logic [TM_WIDTH-1:0]  cnt, cnt_nx;
    logic [TM_WIDTH-1:0]  tm_lat, tm_lat_nx;
    logic                 advance;
    logic [IDX_WIDTH-1:0] idx_nx;
    logic                 dir_nx;

    // Returns {dir, idx} of the frame that follows the current one.
    function automatic logic [IDX_WIDTH:0] next_frame(
        input logic [IDX_WIDTH-1:0] idx,
        input logic                 d,
        input logic                 pp
    );
        logic [IDX_WIDTH-1:0] n;
        logic                 nd;
        if (!pp) begin
            nd = 1'b0;
            n  = (idx == LAST) ? '0 : idx + IDX_WIDTH'(1);
        end else if (!d) begin
            nd = (idx == LAST);
            n  = (idx == LAST) ? LAST - IDX_WIDTH'(1) : idx + IDX_WIDTH'(1);
        end else begin
            nd = (idx != '0);
            n  = (idx == '0) ? IDX_WIDTH'(1) : idx - IDX_WIDTH'(1);
        end
        return {nd, n};
    endfunction

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        tm_lat_nx = tm_lat;
        advance   = 1'b0;
        if (!count_en || tm_value == '0) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx  = RUN;
                    cnt_nx    = '0;
                    tm_lat_nx = tm_value;
                end
                RUN: begin
                    if (btn_pause) state_nx = PAUSE;
                    // A speed change restarts the period and masks any terminal count.
                    if (tm_value != tm_lat) begin
                        tm_lat_nx = tm_value;
                        cnt_nx    = '0;
                    end else if (!btn_pause) begin
                        if (cnt == tm_lat - TM_WIDTH'(1)) begin
                            cnt_nx  = '0;
                            advance = 1'b1;
                        end else begin
                            cnt_nx = cnt + TM_WIDTH'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (btn_pause) state_nx = RUN;
                    if (tm_value != tm_lat) begin
                        tm_lat_nx = tm_value;
                        cnt_nx    = '0;
                    end else if (!btn_pause && btn_step) begin
                        cnt_nx  = '0;
                        advance = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        {dir_nx, idx_nx} = advance ? next_frame(frame_idx, dir, pingpong) : {dir, frame_idx};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tm_lat    <= '0;
            step      <= 1'b0;
            frame_idx <= '0;
            dir       <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tm_lat    <= tm_lat_nx;
            step      <= advance;
            frame_idx <= idx_nx;
            dir       <= dir_nx;
            running   <= (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_anim_step_ctrl.sv
// Scoreboard bench for anim_step_ctrl: a timing/frame-order model pushes expected
// responses per clock and per step strobe; a monitor pops and compares them.
module tb_anim_step_ctrl;

    localparam int TW = 8;
    localparam int F  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] tm_value;
    logic          count_en, btn_pause, btn_step, pingpong;
    logic          step;
    logic [IW-1:0] frame_idx;
    logic          dir, running;

    anim_step_ctrl #(.TM_WIDTH(TW), .FRAMES(F), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .tm_value(tm_value), .count_en(count_en),
        .btn_pause(btn_pause), .btn_step(btn_step), .pingpong(pingpong),
        .step(step), .frame_idx(frame_idx), .dir(dir), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct { bit stp; bit run; int idx; bit dir; } cyc_t;
    typedef struct { int cyc; int idx; bit dir; } stp_t;

    cyc_t cq[$];
    stp_t sq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference state: whether animating, whether paused, period and clocks since last step.
    bit m_active, m_paused, m_dir;
    int m_period, m_phase, m_idx;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Ping-pong order viewed as a ring of 2F-2 positions; wrap order as a ring of F.
    function automatic void m_advance(bit pp);
        int pos;
        if (!pp) begin
            m_idx = (m_idx + 1) % F;
            m_dir = 1'b0;
        end else begin
            pos = m_dir ? (2*F - 2 - m_idx) % (2*F - 2) : m_idx;
            pos = (pos + 1) % (2*F - 2);
            if (pos == 0) begin
                m_idx = 0; m_dir = 1'b1;
            end else if (pos <= F - 1) begin
                m_idx = pos; m_dir = 1'b0;
            end else begin
                m_idx = 2*F - 2 - pos; m_dir = 1'b1;
            end
        end
    endfunction

    function automatic void model_edge();
        bit stp = 1'b0;
        if (!rst) begin
            m_active = 0; m_paused = 0; m_period = 0; m_phase = 0; m_idx = 0; m_dir = 0;
        end else if (!count_en || tm_value == 0) begin
            m_active = 0; m_paused = 0; m_phase = 0;
        end else if (!m_active) begin
            m_active = 1; m_paused = 0; m_period = int'(tm_value); m_phase = 0;
        end else if (int'(tm_value) != m_period) begin
            m_period = int'(tm_value);
            m_phase  = 0;
            if (btn_pause) m_paused = !m_paused;
        end else if (btn_pause) begin
            m_paused = !m_paused;
        end else if (!m_paused) begin
            if (m_phase + 1 == m_period) begin
                m_phase = 0; stp = 1'b1;
            end else begin
                m_phase++;
            end
        end else if (btn_step) begin
            m_phase = 0; stp = 1'b1;
        end
        if (stp) begin
            m_advance(pingpong);
            sq.push_back('{cyc, m_idx, m_dir});
        end
        cq.push_back('{stp, m_active && !m_paused, m_idx, m_dir});
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1; tick(); btn_pause = 1'b0;
    endtask

    task automatic pulse_step();
        btn_step = 1'b1; tick(); btn_step = 1'b0;
    endtask

    cyc_t c;
    stp_t s;

    always @(negedge clk) begin
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("step", {31'd0, step}, {31'd0, c.stp});
            chk("running", {31'd0, running}, {31'd0, c.run});
            chk("frame_idx", {30'd0, frame_idx}, c.idx);
            chk("dir", {31'd0, dir}, {31'd0, c.dir});
            if (c.stp && step !== 1'b1 && sq.size() > 0) sq.delete(0);
        end
        if (step === 1'b1) begin
            if (sq.size() == 0) begin
                chk("step_expected", 32'd1, 32'd0);
            end else begin
                s = sq.pop_front();
                chk("step_cycle", cyc, s.cyc);
                chk("step_idx", {30'd0, frame_idx}, s.idx);
                chk("step_dir", {31'd0, dir}, {31'd0, s.dir});
            end
        end
    end

    initial begin
        rst = 1'b0; tm_value = '0; count_en = 1'b0;
        btn_pause = 1'b0; btn_step = 1'b0; pingpong = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Wrap order, period 4
        count_en = 1'b1; tm_value = 8'd4;
        repeat (20) tick();

        // Ping-pong at one step per clock
        pingpong = 1'b1; tm_value = 8'd1;
        repeat (12) tick();

        // Pause / single step / resume at period 10
        pingpong = 1'b0; tm_value = 8'd10;
        repeat (7) tick();
        pulse_pause();
        repeat (50) tick();
        pulse_step();
        repeat (3) tick();
        btn_pause = 1'b1; btn_step = 1'b1; tick();
        btn_pause = 1'b0; btn_step = 1'b0;
        repeat (14) tick();

        // Speed change mid-period
        repeat (8) tick();
        tm_value = 8'd3;
        repeat (10) tick();

        // Enable dropped in RUN and in PAUSE
        count_en = 1'b0; repeat (3) tick();
        count_en = 1'b1; repeat (8) tick();
        pulse_pause(); repeat (2) tick();
        count_en = 1'b0; repeat (2) tick();
        count_en = 1'b1; repeat (8) tick();

        // Asynchronous reset between clock edges
        tm_value = 8'd2; repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        chk("async_step", {31'd0, step}, 32'd0);
        chk("async_frame_idx", {30'd0, frame_idx}, 32'd0);
        chk("async_dir", {31'd0, dir}, 32'd0);
        chk("async_running", {31'd0, running}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            count_en  = ($urandom % 100) >= 2;
            if (($urandom % 100) < 3) tm_value = TW'($urandom_range(0, 6));
            btn_pause = ($urandom % 100) < 4;
            btn_step  = ($urandom % 100) < 10;
            if (($urandom % 100) < 3) pingpong = !pingpong;
            tick();
        end
        btn_pause = 1'b0; btn_step = 1'b0;
        repeat (3) tick();

        chk("pending_steps", sq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/anim_step_ctrl.md
Name: anim_step_ctrl

Overview:
Sequencer for the LED display animation. Consumes the speed selection (tm_value, count_en) from the switch-mode decoder and produces a one-cycle step strobe every tm_value clocks, plus the current frame index for the pattern ROM/shift logic. Adds run/pause, single-step and wrap/ping-pong frame ordering. Sits between the speed decoder and the display pattern generator.

Parameters:
TM_WIDTH, 27, width of tm_value and internal period counter
FRAMES, 8, number of animation frames (legal range 2..2**IDX_WIDTH)
IDX_WIDTH, 3, width of frame_idx

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tm_value  in  TM_WIDTH  step period in clocks; 0 = stopped
count_en  in  1  animation enable from speed decoder
btn_pause  in  1  debounced one-cycle pulse; toggles run/pause
btn_step  in  1  debounced one-cycle pulse; single step while paused
pingpong  in  1  level; 0 = wrap ordering, 1 = bounce ordering
step  out  1  one-cycle pulse, coincident with each frame_idx update
frame_idx  out  IDX_WIDTH  current frame
dir  out  1  0 = ascending, 1 = descending (ping-pong only)
running  out  1  high while in RUN

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, tm_lat=0, step=0, frame_idx=0, dir=0, running=0. All outputs registered.
- States: IDLE, RUN, PAUSE. running = (state==RUN), registered.
- Any state -> IDLE when count_en=0 or tm_value=0 (highest priority). In IDLE: cnt=0, step=0, frame_idx and dir held.
- IDLE -> RUN when count_en=1 and tm_value!=0; cnt=0, tm_lat<=tm_value. Never exits IDLE directly to PAUSE.
- RUN: cnt increments each clock. At the edge where cnt==tm_lat-1: cnt<=0, step<=1, frame advances on that same edge. Step period is exactly tm_lat clocks; tm_value=1 gives step every cycle.
- Speed change: in RUN or PAUSE, if tm_value!=tm_lat (and nonzero) then tm_lat<=tm_value, cnt<=0, no step on that edge; takes priority over a terminal count in the same cycle.
- RUN -> PAUSE on btn_pause: cnt held, no step. PAUSE -> RUN on btn_pause: counting resumes from the held cnt.
- PAUSE + btn_step: next edge step<=1, frame advances, cnt<=0. btn_step in RUN or IDLE is ignored.
- btn_pause and btn_step in the same cycle while paused: pause wins (resume), step ignored. btn_pause in IDLE is ignored.
- Frame advance, pingpong=0: frame_idx <= (frame_idx==FRAMES-1) ? 0 : frame_idx+1; dir<=0.
- Frame advance, pingpong=1: dir=0: at FRAMES-1 set dir=1, idx=FRAMES-2, else idx+1. dir=1: at 0 set dir=0, idx=1, else idx-1.
- pingpong changes apply at the next advance only; frame_idx is never altered without a step.
- frame_idx outside 0..FRAMES-1 is unreachable.
- Counter width: cnt is TM_WIDTH bits; comparison is against tm_lat-1 and never overflows.

Test Plan:
- FRAMES=4, pingpong=0, tm_value=4, count_en=1 after reset -> step at clocks 4,8,12,16 after RUN entry; frame_idx 1,2,3,0; running=1.
- FRAMES=4, pingpong=1, tm_value=1 -> frame_idx 1,2,3,2,1,0,1 on consecutive cycles; dir rises with the 3->2 step and falls with the 0->1 step.
- tm_value=10, btn_pause at cnt=6 -> no step for 50 cycles, running=0. btn_step -> one step, cnt=0. btn_pause -> next step exactly 10 clocks later.
- tm_value changed 10->3 at cnt=8 -> no step that edge; next step 3 clocks after the change, then every 3.
- count_en dropped mid-count in RUN or PAUSE -> IDLE, step=0, frame_idx held. Re-raised -> RUN with cnt=0, first step after a full period.
- rst asserted asynchronously mid-period -> all outputs 0 immediately, without a clock edge. Release -> IDLE, then RUN on the next edge.
